rr_mux_arbiter: RTL and testbench



---
 rtl/rr_mux_arbiter.sv | 143 ++++++++++++++
 tb/tb_rr_mux_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter
//   Round-robin arbiter that shares one 8-to-1, DW-bit selection mux among
//   8 requesters. A winner is held for a burst of up to MAX_BURST beats
//   (valid/ready toward one consumer) and is then rotated out.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req        in   [7:0]      per-requester request
//   d_in       in   [8*DW-1:0] flattened requester data, slice i = [i*DW +: DW]
//   out_ready  in   downstream accepts a beat this cycle
//   gnt        out  [7:0]      one-hot grant, zero when idle (registered)
//   sel        out  [2:0]      mux select of the granted requester (registered)
//   out_data   out  [DW-1:0]   d_in slice selected by sel
//   out_valid  out  beat offered (GRANT and req[sel])
//   busy       out  state == GRANT
//
// Optional build macro ARB_STATS_EN adds:
//   stats_clr   in   synchronous clear of grant_count (wins over increment)
//   grant_count out  [15:0] saturating count of new grants
// ---------------------------------------------------------------------------
module rr_mux_arbiter #(
    parameter int DW        = 4,
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      req,
    input  logic [8*DW-1:0] d_in,
    input  logic            out_ready,
`ifdef ARB_STATS_EN
    input  logic            stats_clr,
    output logic [15:0]     grant_count,
`endif
    output logic [7:0]      gnt,
    output logic [2:0]      sel,
    output logic [DW-1:0]   out_data,
    output logic            out_valid,
    output logic            busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state;
    logic [2:0] ptr;
    logic [3:0] beat_cnt;

    logic       xfer;
    logic       release_now;
    logic [7:0] arb_req;
    logic [2:0] arb_ptr;
    logic [2:0] winner;
    logic       new_grant;

    // First set bit of r scanning p, p+1, ... mod 8.
    function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        pick = p;
        // Walk from the farthest offset down so the nearest set bit wins last.
        for (int i = 7; i >= 0; i--) begin
            idx = p + 3'(i);
            if (r[idx]) pick = idx;
        end
    endfunction

    assign busy      = (state == GRANT);
    assign out_valid = busy && req[sel];
    assign out_data  = d_in[sel*DW +: DW];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        xfer        = out_valid && out_ready;
        release_now = 1'b0;
        arb_req     = req;
        arb_ptr     = ptr;
        if (busy) begin
            release_now = !req[sel] || (xfer && beat_cnt == 4'(MAX_BURST - 1));
            // On a release the outgoing requester is masked for this one
            // decision and the scan starts just past it.
            arb_req     = req & ~(8'b1 << sel);
            arb_ptr     = sel + 3'd1;
        end
        winner    = pick(arb_req, arb_ptr);
        new_grant = (busy ? release_now : 1'b1) && (arb_req != 8'b0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= 8'b0;
            sel      <= 3'd0;
            ptr      <= 3'd0;
            beat_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (new_grant) begin
                        state    <= GRANT;
                        sel      <= winner;
                        gnt      <= 8'b1 << winner;
                        beat_cnt <= 4'd0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        ptr      <= sel + 3'd1;
                        beat_cnt <= 4'd0;
                        if (new_grant) begin
                            sel <= winner;
                            gnt <= 8'b1 << winner;
                        end else begin
                            state <= IDLE;
                            gnt   <= 8'b0;
                        end
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 8'b0;
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_count <= 16'd0;
        end else if (stats_clr) begin
            grant_count <= 16'd0;
        end else if (new_grant && grant_count != 16'hFFFF) begin
            grant_count <= grant_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

    localparam int DW = 4;

    logic            clk;
    logic            rst_n;
    logic [7:0]      req;
    logic [8*DW-1:0] d_in;
    logic            out_ready;
    logic [7:0]      gnt;
    logic [2:0]      sel;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            busy;
`ifdef ARB_STATS_EN
    logic            stats_clr;
    logic [15:0]     grant_count;
`endif

    int checks = 0;
    int passed = 0;

    rr_mux_arbiter #(.DW(DW), .MAX_BURST(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .d_in       (d_in),
        .out_ready  (out_ready),
`ifdef ARB_STATS_EN
        .stats_clr  (stats_clr),
        .grant_count(grant_count),
`endif
        .gnt        (gnt),
        .sel        (sel),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // Advance one clock; outputs are then observed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Slice i holds i ^ 9, so slice 3 = 4'hA and slice 0 = 4'h9.
        for (int i = 0; i < 8; i++) d_in[i*DW +: DW] = 4'(i ^ 9);
        rst_n     = 1'b0;
        req       = 8'h00;
        out_ready = 1'b0;
`ifdef ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        tick();
        check("rst_gnt",   16'(gnt), 16'h00);
        check("rst_sel",   16'(sel), 16'h0);
        check("rst_busy",  16'(busy), 16'h0);
        check("rst_valid", 16'(out_valid), 16'h0);
        check("rst_data",  16'(out_data), 16'h9);

        // Reset mid-burst: grant 2, two beats, then async reset.
        rst_n = 1'b1; req = 8'h04; out_ready = 1'b1;
        tick();
        check("mid_gnt",   16'(gnt), 16'h04);
        check("mid_sel",   16'(sel), 16'h2);
        check("mid_valid", 16'(out_valid), 16'h1);
        tick();
        tick();
        check("mid_hold",  16'(gnt), 16'h04);
        rst_n = 1'b0;
        #1;
        check("arst_gnt",   16'(gnt), 16'h00);
        check("arst_valid", 16'(out_valid), 16'h0);
        check("arst_busy",  16'(busy), 16'h0);
        req = 8'h00;
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_idle", 16'(busy), 16'h0);
        check("post_rst_gnt",  16'(gnt), 16'h00);

        // Round-robin with all requesting: pointer restarts at 0 after reset.
        req = 8'hFF;
        tick();
        for (int k = 0; k < 9; k++) begin
            check($sformatf("rr_gnt%0d", k), 16'(gnt), 16'(8'b1 << (k % 8)));
            check($sformatf("rr_sel%0d", k), 16'(sel), 16'(k % 8));
            for (int b = 1; b < 4; b++) begin
                tick();
                check($sformatf("rr_hold%0d_%0d", k, b), 16'(gnt), 16'(8'b1 << (k % 8)));
            end
            if (k == 8) req = 8'h00;
            tick();
        end
        check("rr_end_idle", 16'(busy), 16'h0);

        // Single requester 3: 4 beats, one idle cycle, re-grant.
        req = 8'h08;
        tick();
        check("single_gnt",  16'(gnt), 16'h08);
        check("single_sel",  16'(sel), 16'h3);
        check("single_data", 16'(out_data), 16'hA);
        for (int b = 1; b < 4; b++) begin
            tick();
            check($sformatf("single_hold%0d", b), 16'(gnt), 16'h08);
        end
        tick();
        check("single_idle_gnt",  16'(gnt), 16'h00);
        check("single_idle_busy", 16'(busy), 16'h0);
        tick();
        check("single_regnt", 16'(gnt), 16'h08);
        req = 8'h00;
        tick();
        check("single_drop", 16'(gnt), 16'h00);

        // Move the pointer to 6 by granting 5 alone and withdrawing.
        req = 8'h20;
        tick();
        check("ptr_setup_gnt", 16'(gnt), 16'h20);
        req = 8'h00;
        tick();
        check("ptr_setup_idle", 16'(gnt), 16'h00);

        // Wrap and skip: pointer 6, requesters 0 and 5.
        req = 8'h21;
        tick();
        check("wrap_gnt0", 16'(gnt), 16'h01);
        for (int b = 1; b < 4; b++) begin
            tick();
            check($sformatf("wrap_hold0_%0d", b), 16'(gnt), 16'h01);
        end
        tick();
        check("wrap_gnt5", 16'(gnt), 16'h20);
        check("wrap_sel5", 16'(sel), 16'h5);
        repeat (4) tick();
        check("wrap_back0", 16'(gnt), 16'h01);
        req = 8'h00;
        tick();
        check("wrap_idle", 16'(gnt), 16'h00);

        // Stall then withdraw: requester 4 stalled, then hands over to 1.
        req = 8'h10; out_ready = 1'b0;
        tick();
        check("stall_gnt", 16'(gnt), 16'h10);
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("stall_hold%0d", c), 16'(gnt), 16'h10);
        end
        check("stall_valid", 16'(out_valid), 16'h1);
        req = 8'h02;
        tick();
        check("withdraw_gnt", 16'(gnt), 16'h02);
        check("withdraw_sel", 16'(sel), 16'h1);
        out_ready = 1'b1;
        for (int b = 1; b < 4; b++) begin
            tick();
            check($sformatf("after_hold%0d", b), 16'(gnt), 16'h02);
        end
        req = 8'h00;
        tick();
        check("after_idle", 16'(gnt), 16'h00);

`ifdef ARB_STATS_EN
        // A granted requester withdraws every cycle, forcing a new grant
        // each cycle until the counter saturates.
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        check("stats_clr0", grant_count, 16'h0000);
        for (int n = 0; n < 70000; n++) begin
            req = (gnt == 8'h00) ? 8'hFF : ~gnt;
            tick();
        end
        check("stats_sat", grant_count, 16'hFFFF);
        req = 8'h00;
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        check("stats_clr", grant_count, 16'h0000);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
